adc_rcv_align: RTL and testbench

- Automatic per-line alignment controller for the multi-channel ADC deserialiser front end. It runs in the fabric clock domain and sits between the ISERDES/IODELAY receive slices and the channel logic.
- While the ADC outputs a fixed training word, it scans each line's IODELAY to find the data eye and centres the delay in it. It then issues bitslips until the deserialised word equals the training pattern.
- Channels are aligned one after another. Per-channel status and chosen taps are reported.

---
 rtl/adc_rcv_align.sv | 266 ++++++++++++++++++++++++++
 tb/tb_adc_rcv_align.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_rcv_align.sv
// ADC receive-line aligner: scans each line's IODELAY for the data eye, centres
// the tap in it, then bitslips until the deserialised word equals the training pattern.
module adc_rcv_align #(
    parameter int            NCH       = 4,
    parameter int            DW        = 6,
    parameter logic [DW-1:0] PATTERN   = 6'b111000,
    parameter int            TAPW      = 8,
    parameter int            SETTLE    = 8,
    parameter int            CHECK_LEN = 16,
    parameter int            MIN_EYE   = 4
) (
    input  logic                CLK,
    input  logic                RST_N,
    input  logic                START,
    input  logic [NCH*DW-1:0]   DIN,
    output logic [NCH-1:0]      BS,
    output logic [NCH-1:0]      DINC,
    output logic [NCH-1:0]      DRST,
    output logic                BUSY,
    output logic                DONE,
    output logic [NCH-1:0]      ERR,
    output logic [NCH*TAPW-1:0] TAP
);

    localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int CW  = $clog2(((SETTLE > CHECK_LEN) ? SETTLE : CHECK_LEN) + 1);
    localparam int SW  = $clog2(DW);
    localparam int EW  = TAPW + 1;

    localparam logic [TAPW-1:0] TAP_MAX   = {TAPW{1'b1}};
    localparam logic [CW-1:0]   SET_LAST  = CW'(SETTLE - 1);
    localparam logic [CW-1:0]   CHK_LAST  = CW'(CHECK_LEN - 1);
    localparam logic [SW-1:0]   SLIP_LAST = SW'(DW - 1);
    localparam logic [EW-1:0]   MIN_W     = EW'(MIN_EYE);
    localparam logic [CHW-1:0]  CH_LAST   = CHW'(NCH - 1);

    typedef enum logic [3:0] {
        S_IDLE, S_RSTDLY, S_WAIT, S_CHECK, S_STEP, S_DRSTERR,
        S_CRST, S_CINC, S_CGAP, S_SLIP, S_NEXT, S_FINISH
    } state_t;

    state_t                    state_q, state_d, ret_q, ret_d;
    logic [CHW-1:0]            ch_q, ch_d;
    logic [TAPW-1:0]           tap_q, tap_d, t_start_q, t_start_d;
    logic [TAPW-1:0]           center_q, center_d, inc_q, inc_d;
    logic                      in_eye_q, in_eye_d;
    logic [CW-1:0]             cnt_q, cnt_d;
    logic [DW-1:0]             ref_q, ref_d;
    logic                      mism_q, mism_d;
    logic [SW-1:0]             slips_q, slips_d;
    logic                      busy_d, done_d;
    logic [NCH-1:0]            err_d, bs_d, dinc_d, drst_d;
    logic [NCH-1:0][TAPW-1:0]  taps_q, taps_d;

    logic [DW-1:0]   din_ch, ref_eff;
    logic            first, stable, pass, open_now, closing;
    logic [TAPW-1:0] start_eff, t_end, center_c;
    logic [EW-1:0]   width, sum;

    function automatic logic is_rotation(input logic [DW-1:0] w);
        logic [DW-1:0] r;
        logic          hit;
        r   = PATTERN;
        hit = 1'b0;
        for (int i = 0; i < DW; i++) begin
            if (w == r) hit = 1'b1;
            r = {r[DW-2:0], r[DW-1]};
        end
        return hit;
    endfunction

    always_comb begin
        din_ch = '0;
        for (int n = 0; n < NCH; n++)
            if (ch_q == CHW'(n)) din_ch = DIN[n*DW +: DW];
    end

    // The word captured on the first CHECK cycle is the reference for the rest of the window.
    assign first     = (cnt_q == '0);
    assign ref_eff   = first ? din_ch : ref_q;
    assign stable    = first | (!mism_q && (din_ch == ref_q));
    assign pass      = stable && is_rotation(ref_eff);
    assign open_now  = pass && !in_eye_q;
    assign start_eff = open_now ? tap_q : t_start_q;
    assign closing   = (in_eye_q || pass) && (!pass || (tap_q == TAP_MAX));
    assign t_end     = pass ? tap_q : tap_q - TAPW'(1);
    assign width     = {1'b0, t_end} - {1'b0, start_eff} + EW'(1);
    assign sum       = {1'b0, start_eff} + {1'b0, t_end};
    assign center_c  = TAPW'(sum >> 1);

    always_comb begin
        // NOTE: every variable written here gets a default first, so no path infers a latch.
        state_d   = state_q;
        ret_d     = ret_q;
        ch_d      = ch_q;
        tap_d     = tap_q;
        t_start_d = t_start_q;
        center_d  = center_q;
        inc_d     = inc_q;
        in_eye_d  = in_eye_q;
        cnt_d     = cnt_q;
        ref_d     = ref_q;
        mism_d    = mism_q;
        slips_d   = slips_q;
        busy_d    = BUSY;
        done_d    = DONE;
        err_d     = ERR;
        taps_d    = taps_q;
        bs_d      = '0;
        dinc_d    = '0;
        drst_d    = '0;

        unique case (state_q)
            S_IDLE: begin
                if (START) begin
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                    err_d   = '0;
                    ch_d    = '0;
                    state_d = S_RSTDLY;
                end
            end
            S_RSTDLY: begin
                drst_d[ch_q] = 1'b1;
                tap_d        = '0;
                in_eye_d     = 1'b0;
                ret_d        = S_CHECK;
                state_d      = S_WAIT;
            end
            S_WAIT: begin
                if (cnt_q == SET_LAST) begin
                    cnt_d   = '0;
                    state_d = ret_q;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_CHECK: begin
                ref_d  = ref_eff;
                mism_d = !stable;
                cnt_d  = cnt_q + CW'(1);
                if (cnt_q == CHK_LAST) begin
                    cnt_d     = '0;
                    in_eye_d  = (in_eye_q || pass) && !closing;
                    t_start_d = start_eff;
                    if (closing && (width >= MIN_W)) begin
                        center_d = center_c;
                        state_d  = S_CRST;
                    end else if (tap_q == TAP_MAX) begin
                        err_d[ch_q]  = 1'b1;
                        taps_d[ch_q] = '0;
                        state_d      = S_DRSTERR;
                    end else begin
                        state_d = S_STEP;
                    end
                end
            end
            S_STEP: begin
                dinc_d[ch_q] = 1'b1;
                tap_d        = tap_q + TAPW'(1);
                ret_d        = S_CHECK;
                state_d      = S_WAIT;
            end
            S_DRSTERR: begin
                drst_d[ch_q] = 1'b1;
                ret_d        = S_NEXT;
                state_d      = S_WAIT;
            end
            S_CRST: begin
                drst_d[ch_q] = 1'b1;
                inc_d        = '0;
                ret_d        = S_CINC;
                state_d      = S_WAIT;
            end
            // Centring walks the delay up from zero at one increment every other cycle.
            S_CINC: begin
                if (inc_q == center_q) begin
                    taps_d[ch_q] = center_q;
                    slips_d      = '0;
                    ret_d        = S_SLIP;
                    state_d      = S_WAIT;
                end else begin
                    dinc_d[ch_q] = 1'b1;
                    inc_d        = inc_q + TAPW'(1);
                    state_d      = S_CGAP;
                end
            end
            S_CGAP: state_d = S_CINC;
            S_SLIP: begin
                if (din_ch == PATTERN) begin
                    state_d = S_NEXT;
                end else if (slips_q == SLIP_LAST) begin
                    err_d[ch_q] = 1'b1;
                    state_d     = S_NEXT;
                end else begin
                    bs_d[ch_q] = 1'b1;
                    slips_d    = slips_q + SW'(1);
                    ret_d      = S_SLIP;
                    state_d    = S_WAIT;
                end
            end
            S_NEXT: begin
                if (ch_q == CH_LAST) begin
                    state_d = S_FINISH;
                end else begin
                    ch_d    = ch_q + CHW'(1);
                    state_d = S_RSTDLY;
                end
            end
            S_FINISH: begin
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q   <= S_IDLE;
            ret_q     <= S_IDLE;
            ch_q      <= '0;
            tap_q     <= '0;
            t_start_q <= '0;
            center_q  <= '0;
            inc_q     <= '0;
            in_eye_q  <= 1'b0;
            cnt_q     <= '0;
            ref_q     <= '0;
            mism_q    <= 1'b0;
            slips_q   <= '0;
            BUSY      <= 1'b0;
            DONE      <= 1'b0;
            ERR       <= '0;
            taps_q    <= '0;
            BS        <= '0;
            DINC      <= '0;
            DRST      <= '0;
        end else begin
            state_q   <= state_d;
            ret_q     <= ret_d;
            ch_q      <= ch_d;
            tap_q     <= tap_d;
            t_start_q <= t_start_d;
            center_q  <= center_d;
            inc_q     <= inc_d;
            in_eye_q  <= in_eye_d;
            cnt_q     <= cnt_d;
            ref_q     <= ref_d;
            mism_q    <= mism_d;
            slips_q   <= slips_d;
            BUSY      <= busy_d;
            DONE      <= done_d;
            ERR       <= err_d;
            taps_q    <= taps_d;
            BS        <= bs_d;
            DINC      <= dinc_d;
            DRST      <= drst_d;
        end
    end

    assign TAP = taps_q;

endmodule

// File: tb/tb_adc_rcv_align.sv
// Scoreboard bench for adc_rcv_align: behavioural IODELAY/ISERDES line models feed DIN,
// a monitor compares command order and per-line results against queued expectations.
module tb_adc_rcv_align;

    localparam int            NCH     = 4;
    localparam int            DW      = 6;
    localparam int            TAPW    = 8;
    localparam logic [DW-1:0] PATTERN = 6'b111000;

    logic                CLK = 1'b0;
    logic                RST_N = 1'b0;
    logic                START = 1'b0;
    logic [NCH*DW-1:0]   DIN;
    logic [NCH-1:0]      BS, DINC, DRST, ERR;
    logic                BUSY, DONE;
    logic [NCH*TAPW-1:0] TAP;

    adc_rcv_align #(
        .NCH(NCH), .DW(DW), .PATTERN(PATTERN), .TAPW(TAPW),
        .SETTLE(8), .CHECK_LEN(16), .MIN_EYE(4)
    ) dut (
        .CLK(CLK), .RST_N(RST_N), .START(START), .DIN(DIN),
        .BS(BS), .DINC(DINC), .DRST(DRST), .BUSY(BUSY), .DONE(DONE),
        .ERR(ERR), .TAP(TAP)
    );

    always #5 CLK = ~CLK;

    typedef enum int {M_EYE, M_RANDOM, M_CONST} mode_t;

    typedef struct packed {
        logic [NCH-1:0]           err;
        logic [NCH-1:0][TAPW-1:0] tap;
        logic [NCH-1:0][TAPW-1:0] dinc;   // DINC pulses after the line's last DRST
        logic [NCH-1:0][2:0]      bs;
    } exp_t;

    mode_t         mode[NCH];
    int            eye_lo[NCH], eye_hi[NCH], eye2_lo[NCH], eye2_hi[NCH];
    int            tap_m[NCH], rot_m[NCH];
    logic [DW-1:0] const_w[NCH];

    exp_t done_q[$];
    int   drst_q[$];
    int   n_checks = 0;
    int   n_fail = 0;
    int   dinc_cnt[NCH], bs_cnt[NCH], drst_seen[NCH];
    int   viol;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] rotl(input logic [DW-1:0] w, input int r);
        logic [DW-1:0] x;
        x = w;
        for (int i = 0; i < r; i++) x = {x[DW-2:0], x[DW-1]};
        return x;
    endfunction

    function automatic logic [DW-1:0] line_word(input int n);
        logic in_eye;
        in_eye = (tap_m[n] >= eye_lo[n] && tap_m[n] <= eye_hi[n]) ||
                 (tap_m[n] >= eye2_lo[n] && tap_m[n] <= eye2_hi[n]);
        case (mode[n])
            M_EYE:   return in_eye ? rotl(PATTERN, rot_m[n]) : DW'($urandom);
            M_CONST: return const_w[n];
            default: return DW'($urandom);
        endcase
    endfunction

    task automatic configure(input int n, input mode_t m, input int lo, input int hi,
                             input int lo2, input int hi2, input int rot);
        mode[n]    = m;
        eye_lo[n]  = lo;
        eye_hi[n]  = hi;
        eye2_lo[n] = lo2;
        eye2_hi[n] = hi2;
        rot_m[n]   = rot;
        tap_m[n]   = 0;
        const_w[n] = '0;
    endtask

    // Line model: IODELAY tap and bitslip position follow the DUT's command pulses.
    initial begin
        DIN = '0;
        forever begin
            @(negedge CLK);
            for (int n = 0; n < NCH; n++) begin
                if (DRST[n]) tap_m[n] = 0;
                else if (DINC[n]) tap_m[n] = tap_m[n] + 1;
                if (BS[n]) rot_m[n] = (rot_m[n] + 1) % DW;
                DIN[n*DW +: DW] = line_word(n);
            end
        end
    end

    // Monitor: pops expected DRST order and per-run results as the DUT presents them.
    initial begin
        logic           done_prev;
        logic [NCH-1:0] bs_prev, dinc_prev, drst_prev;
        int             e;
        exp_t           x;
        done_prev = 1'b0;
        bs_prev   = '0;
        dinc_prev = '0;
        drst_prev = '0;
        forever begin
            @(negedge CLK);
            if (!RST_N) begin
                done_prev = 1'b0;
                bs_prev   = '0;
                dinc_prev = '0;
                drst_prev = '0;
                continue;
            end
            if ($countones({BS, DINC, DRST}) > 1) viol++;
            if (((BS & bs_prev) | (DINC & dinc_prev) | (DRST & drst_prev)) != '0) viol++;
            if (DRST != '0) begin
                if (drst_q.size() == 0) begin
                    check("drst_unexpected", 64'(DRST), 64'd0);
                end else begin
                    e = drst_q.pop_front();
                    check("drst_line", 64'(DRST), 64'd1 << e);
                end
            end
            for (int n = 0; n < NCH; n++) begin
                if (DRST[n]) begin
                    dinc_cnt[n] = 0;
                    drst_seen[n]++;
                end else if (DINC[n]) begin
                    dinc_cnt[n]++;
                end
                if (BS[n]) bs_cnt[n]++;
            end
            if (DONE && !done_prev) begin
                if (done_q.size() == 0) begin
                    check("done_unexpected", 64'(DONE), 64'd0);
                end else begin
                    x = done_q.pop_front();
                    check("busy_at_done", 64'(BUSY), 64'd0);
                    check("err", 64'(ERR), 64'(x.err));
                    for (int n = 0; n < NCH; n++) begin
                        check($sformatf("tap%0d", n), 64'(TAP[n*TAPW +: TAPW]), 64'(x.tap[n]));
                        check($sformatf("center_dinc%0d", n), 64'(dinc_cnt[n]), 64'(x.dinc[n]));
                        check($sformatf("bs_count%0d", n), 64'(bs_cnt[n]), 64'(x.bs[n]));
                    end
                    check("cmd_rule_viol", 64'(viol), 64'd0);
                    check("drst_left", 64'(drst_q.size()), 64'd0);
                end
            end
            done_prev = DONE;
            bs_prev   = BS;
            dinc_prev = DINC;
            drst_prev = DRST;
        end
    end

    task automatic start_run(input exp_t e);
        for (int n = 0; n < NCH; n++) begin
            dinc_cnt[n]  = 0;
            bs_cnt[n]    = 0;
            drst_seen[n] = 0;
            drst_q.push_back(n);
            drst_q.push_back(n);
        end
        viol = 0;
        done_q.push_back(e);
        @(negedge CLK);
        START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        check("busy_after_start", 64'(BUSY), 64'd1);
        check("done_cleared", 64'(DONE), 64'd0);
    endtask

    task automatic wait_done(input string name, input int budget);
        int i;
        i = 0;
        while (DONE !== 1'b1 && i < budget) begin
            @(negedge CLK);
            i++;
        end
        check({name, "_done_in_budget"}, 64'(DONE), 64'd1);
        if (DONE !== 1'b1) begin
            RST_N = 1'b0;
            done_q.delete();
            drst_q.delete();
            repeat (2) @(negedge CLK);
            RST_N = 1'b1;
        end
        repeat (3) @(negedge CLK);
        check({name, "_done_held"}, 64'(DONE), 64'd1);
        check({name, "_busy_low"}, 64'(BUSY), 64'd0);
    endtask

    task automatic setup_a(output exp_t e);
        configure(0, M_EYE, 10, 30, -1, -1, 2);
        configure(1, M_EYE, 10, 30, -1, -1, 0);
        configure(2, M_EYE, 10, 30, -1, -1, 5);
        configure(3, M_EYE, 10, 30, -1, -1, 3);
        e = '0;
        for (int n = 0; n < NCH; n++) begin
            e.tap[n]  = 8'd20;
            e.dinc[n] = 8'd20;
        end
        e.bs[0] = 3'd4;
        e.bs[1] = 3'd0;
        e.bs[2] = 3'd1;
        e.bs[3] = 3'd3;
    endtask

    initial begin
        exp_t e;
        int   i;

        setup_a(e);
        RST_N = 1'b0;
        repeat (3) @(negedge CLK);
        #1;
        check("rst_bs", 64'(BS), 64'd0);
        check("rst_dinc", 64'(DINC), 64'd0);
        check("rst_drst", 64'(DRST), 64'd0);
        check("rst_busy", 64'(BUSY), 64'd0);
        check("rst_done", 64'(DONE), 64'd0);
        check("rst_err", 64'(ERR), 64'd0);
        check("rst_tap", 64'(TAP), 64'd0);
        RST_N = 1'b1;
        repeat (3) @(negedge CLK);

        // Eye 10..30 on all lines, differing slip offsets; START repeated mid-run on line 1.
        start_run(e);
        repeat (1000) @(negedge CLK);
        START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        wait_done("run_a", 20000);

        // Line 1 never stable.
        configure(0, M_EYE, 10, 30, -1, -1, 2);
        configure(1, M_RANDOM, -1, -1, -1, -1, 0);
        configure(2, M_EYE, 10, 30, -1, -1, 2);
        configure(3, M_EYE, 10, 30, -1, -1, 2);
        e = '0;
        e.err = 4'b0010;
        for (int n = 0; n < NCH; n++) begin
            e.tap[n]  = (n == 1) ? 8'd0 : 8'd20;
            e.dinc[n] = (n == 1) ? 8'd0 : 8'd20;
            e.bs[n]   = (n == 1) ? 3'd0 : 3'd4;
        end
        start_run(e);
        wait_done("run_b", 20000);

        // Eye at tap 0, eye at max tap, narrow eye then wide eye, non-rotation word.
        configure(0, M_EYE, 0, 7, -1, -1, 1);
        configure(1, M_EYE, 250, 255, -1, -1, 0);
        configure(2, M_EYE, 5, 6, 40, 60, 4);
        configure(3, M_CONST, -1, -1, -1, -1, 0);
        e = '0;
        e.err     = 4'b1000;
        e.tap[0]  = 8'd3;
        e.dinc[0] = 8'd3;
        e.bs[0]   = 3'd5;
        e.tap[1]  = 8'd252;
        e.dinc[1] = 8'd252;
        e.tap[2]  = 8'd50;
        e.dinc[2] = 8'd50;
        e.bs[2]   = 3'd2;
        start_run(e);
        wait_done("run_c", 25000);

        // Reset while line 2 is scanning, then a clean restart from line 0.
        setup_a(e);
        start_run(e);
        i = 0;
        while (drst_seen[2] == 0 && i < 5000) begin
            @(negedge CLK);
            i++;
        end
        check("reached_line2", 64'(drst_seen[2] != 0), 64'd1);
        repeat (50) @(negedge CLK);
        #2;
        RST_N = 1'b0;
        #1;
        check("abort_bs", 64'(BS), 64'd0);
        check("abort_dinc", 64'(DINC), 64'd0);
        check("abort_drst", 64'(DRST), 64'd0);
        check("abort_busy", 64'(BUSY), 64'd0);
        check("abort_done", 64'(DONE), 64'd0);
        check("abort_err", 64'(ERR), 64'd0);
        check("abort_tap", 64'(TAP), 64'd0);
        done_q.delete();
        drst_q.delete();
        repeat (3) @(negedge CLK);
        RST_N = 1'b1;
        repeat (5) @(negedge CLK);
        check("idle_after_abort", 64'({BUSY, DONE, DRST}), 64'd0);
        setup_a(e);
        start_run(e);
        wait_done("run_d", 20000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
